// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_share_arbiter : arbitrates two valid/ready requesters onto one shared ALU
// Optional macro ARB_FIXED_PRIORITY_EN selects fixed priority (req 0 wins).
// Revision: 1.0
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
   parameter int DATA_W      = 32,
   parameter int CTRL_W      = 4,
   parameter int EXEC_CYCLES = 1,
   parameter int MUL_CYCLES  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [CTRL_W-1:0] req0_ctrl,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [CTRL_W-1:0] req1_ctrl,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   output logic [CTRL_W-1:0] alu_ctrl,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_zero
);

   // A configured latency of 0 behaves as 1.
   localparam int c_exec  = (EXEC_CYCLES < 1) ? 1 : EXEC_CYCLES;
   localparam int c_mul   = (MUL_CYCLES < 1) ? 1 : MUL_CYCLES;
   localparam int c_max   = (c_exec > c_mul) ? c_exec : c_mul;
   localparam int c_cnt_w = (c_max < 2) ? 1 : $clog2(c_max);

   localparam logic [CTRL_W-1:0]  c_mul_op  = CTRL_W'(9);
   localparam logic [c_cnt_w-1:0] c_exec_ld = c_cnt_w'(c_exec - 1);
   localparam logic [c_cnt_w-1:0] c_mul_ld  = c_cnt_w'(c_mul - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t             r_state;
   logic [c_cnt_w-1:0] r_cnt;
   logic               r_tag;

   logic              w_grant1;
   logic              w_accept;
   logic [CTRL_W-1:0] w_ctrl;
   logic [DATA_W-1:0] w_a;
   logic [DATA_W-1:0] w_b;

`ifdef ARB_FIXED_PRIORITY_EN
   assign w_grant1 = req1_valid && !req0_valid;
`else
   logic r_ptr;

   assign w_grant1 = req1_valid && (!req0_valid || r_ptr);

   // The requester that was just served loses the next tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= 1'b0;
      end else if (r_state == S_RESP && rsp_ready) begin
         r_ptr <= ~rsp_id;
      end
   end
`endif

   assign w_accept   = rst_n && (r_state == S_IDLE) && (req0_valid || req1_valid);
   assign req0_ready = w_accept && !w_grant1;
   assign req1_ready = w_accept && w_grant1;

   assign w_ctrl = w_grant1 ? req1_ctrl : req0_ctrl;
   assign w_a    = w_grant1 ? req1_a    : req0_a;
   assign w_b    = w_grant1 ? req1_b    : req0_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_tag      <= 1'b0;
         alu_ctrl   <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  alu_ctrl <= w_ctrl;
                  alu_a    <= w_a;
                  alu_b    <= w_b;
                  r_tag    <= w_grant1;
                  r_cnt    <= (w_ctrl == c_mul_op) ? c_mul_ld : c_exec_ld;
                  r_state  <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  rsp_result <= alu_result;
                  rsp_zero   <= alu_zero;
                  rsp_id     <= r_tag;
                  rsp_valid  <= 1'b1;
                  r_state    <= S_RESP;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter : vector table, corner sequences and random traffic
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [3:0]  req0_ctrl, req1_ctrl, alu_ctrl;
   logic [31:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result, rsp_result;
   logic        alu_zero, rsp_valid, rsp_ready, rsp_id, rsp_zero;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   alu_share_arbiter #(.DATA_W(32), .CTRL_W(4), .EXEC_CYCLES(1), .MUL_CYCLES(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
      .req1_a(req1_a), .req1_b(req1_b),
      .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero)
   );

   // Behavioural ALU standing in for the shared unit.
   function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      case (c)
         4'd0:    return a & b;
         4'd1:    return a | b;
         4'd2:    return a + b;
         4'd6:    return a - b;
         4'd9:    return a * b;
         default: return a ^ b;
      endcase
   endfunction

   assign alu_result = alu_f(alu_ctrl, alu_a, alu_b);
   assign alu_zero   = (alu_result == 32'd0);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        id;
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        zero;
      int          lat;
      int          hold;
   } vec_t;

   vec_t vecs[7];

   task automatic drive_req(input logic id, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      if (id) begin
         req1_valid = 1'b1; req1_ctrl = c; req1_a = a; req1_b = b;
      end else begin
         req0_valid = 1'b1; req0_ctrl = c; req0_a = a; req0_b = b;
      end
   endtask

   task automatic do_reset();
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // Single op from IDLE: grant, operand latch, latency, response, backpressure, completion.
   task automatic run_op(input vec_t v);
      int w;
      int lat;
      drive_req(v.id, v.ctrl, v.a, v.b);
      rsp_ready = 1'b0;
      #1;
      w = 0;
      while (!(v.id ? req1_ready : req0_ready) && w < 20) begin
         @(posedge clk); #1; w++;
      end
      check("ready_now", w, 0);
      check("other_ready", v.id ? req0_ready : req1_ready, 0);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      check("alu_ctrl", alu_ctrl, v.ctrl);
      check("alu_a", alu_a, v.a);
      check("alu_b", alu_b, v.b);
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      check("latency", lat, v.lat);
      check("rsp_result", rsp_result, v.res);
      check("rsp_zero", rsp_zero, v.zero);
      check("rsp_id", rsp_id, v.id);
      for (int h = 0; h < v.hold; h++) begin
         req0_valid = 1'b1; req1_valid = 1'b1;
         @(posedge clk); #1;
         check("hold_readies", {req1_ready, req0_ready}, 0);
         check("hold_valid", rsp_valid, 1);
         check("hold_result", rsp_result, v.res);
         check("hold_id", rsp_id, v.id);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("rsp_done", rsp_valid, 0);
      rsp_ready = 1'b0;
   endtask

   logic        pend[2];
   logic [3:0]  pc[2];
   logic [31:0] pa[2];
   logic [31:0] pb[2];
   int          m_phase;
   int          m_wait;
   logic        m_id, m_zero, m_pref, e0, e1, rr, grant;
   logic [31:0] m_res;

   initial begin
      vecs[0] = '{1'b0, 4'd2,  32'd5,          32'd7,          32'd12,     1'b0, 1, 0};
      vecs[1] = '{1'b1, 4'd9,  32'd6,          32'd7,          32'd42,     1'b0, 3, 0};
      vecs[2] = '{1'b0, 4'd6,  32'd3,          32'd3,          32'd0,      1'b1, 1, 5};
      vecs[3] = '{1'b1, 4'd0,  32'hF0F0_0000,  32'h0F0F_FFFF,  32'd0,      1'b1, 1, 1};
      vecs[4] = '{1'b0, 4'd15, 32'h0000_1234,  32'h0000_00FF,  32'h12CB,   1'b0, 1, 2};
      vecs[5] = '{1'b1, 4'd2,  32'hFFFF_FFFF,  32'd1,          32'd0,      1'b1, 1, 0};
      vecs[6] = '{1'b0, 4'd9,  32'h0001_0000,  32'h0001_0000,  32'd0,      1'b1, 3, 0};

      // Reset state, with both requesters asking.
      rst_n = 1'b0; rsp_ready = 1'b0;
      drive_req(1'b0, 4'd2, 32'd1, 32'd2);
      drive_req(1'b1, 4'd2, 32'd3, 32'd4);
      repeat (2) @(posedge clk);
      #1;
      check("rst_readies", {req1_ready, req0_ready}, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_result", rsp_result, 0);
      check("rst_rsp_zero", rsp_zero, 0);
      check("rst_alu", {alu_ctrl, alu_a[27:0]} | alu_b, 0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) run_op(vecs[i]);

      // Reset while a MUL is settling.
      drive_req(1'b0, 4'd9, 32'd11, 32'd13);
      #1;
      check("mul_ready", req0_ready, 1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("abort_rsp_valid", rsp_valid, 0);
      check("abort_alu_a", alu_a, 0);
      check("abort_alu_b", alu_b, 0);
      check("abort_alu_ctrl", alu_ctrl, 0);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check("abort_no_rsp", rsp_valid, 0);
      end
      run_op('{1'b1, 4'd2, 32'd1, 32'd1, 32'd2, 1'b0, 1, 0});

      // Continuous contention: alternating grants (fixed priority: always 0).
      do_reset();
      drive_req(1'b0, 4'd6, 32'd3, 32'd3);
      drive_req(1'b1, 4'd6, 32'd3, 32'd3);
      rsp_ready = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         int w;
         w = 0;
         while (!(req0_ready || req1_ready) && w < 20) begin
            @(posedge clk); #1; w++;
         end
         grant = req1_ready;
`ifdef ARB_FIXED_PRIORITY_EN
         check("cont_grant", grant, 0);
`else
         check("cont_grant", grant, k % 2);
`endif
         @(posedge clk); #1;
         w = 0;
         while (!rsp_valid && w < 20) begin
            @(posedge clk); #1; w++;
         end
         check("cont_result", rsp_result, 0);
         check("cont_zero", rsp_zero, 1);
         check("cont_id", rsp_id, grant);
         @(posedge clk); #1;
         check("cont_done", rsp_valid, 0);
      end

      // Random traffic against a transaction-level model.
      do_reset();
      pend[0] = 1'b0; pend[1] = 1'b0;
      m_phase = 0; m_wait = 0; m_pref = 1'b0;
      m_id = 1'b0; m_res = '0; m_zero = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < 2; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1;
               case ($urandom_range(0, 5))
                  0: pc[i] = 4'd0;
                  1: pc[i] = 4'd1;
                  2: pc[i] = 4'd2;
                  3: pc[i] = 4'd6;
                  4: pc[i] = 4'd9;
                  default: pc[i] = 4'($urandom_range(0, 15));
               endcase
               pa[i] = $urandom;
               pb[i] = ($urandom_range(0, 3) == 0) ? pa[i] : $urandom;
            end
         end
         req0_valid = pend[0]; req0_ctrl = pc[0]; req0_a = pa[0]; req0_b = pb[0];
         req1_valid = pend[1]; req1_ctrl = pc[1]; req1_a = pa[1]; req1_b = pb[1];
         rr = 1'($urandom_range(0, 1));
         rsp_ready = rr;
         #1;
         e0 = 1'b0; e1 = 1'b0;
         if (m_phase == 0) begin
            if (pend[1] && (!pend[0] || m_pref)) e1 = 1'b1;
            else if (pend[0]) e0 = 1'b1;
         end
         check("rnd_readies", {req1_ready, req0_ready}, {e1, e0});
         check("rnd_rsp_valid", rsp_valid, (m_phase == 2));
         if (m_phase == 2) begin
            check("rnd_rsp_id", rsp_id, m_id);
            check("rnd_rsp_result", rsp_result, m_res);
            check("rnd_rsp_zero", rsp_zero, m_zero);
         end
         @(posedge clk); #1;
         if (m_phase == 0 && (e0 || e1)) begin
            m_id    = e1;
            m_res   = alu_f(pc[e1], pa[e1], pb[e1]);
            m_zero  = (m_res == 32'd0);
            m_wait  = (pc[e1] == 4'd9) ? 3 : 1;
            m_phase = 1;
            pend[e1] = 1'b0;
         end else if (m_phase == 1) begin
            m_wait--;
            if (m_wait == 0) m_phase = 2;
         end else if (m_phase == 2 && rr) begin
            m_phase = 0;
`ifndef ARB_FIXED_PRIORITY_EN
            m_pref = ~m_id;
`endif
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 32-bit ALU between two requesters, e.g. the EX stage (requester 0) and the branch/address-compute unit (requester 1).
- Each requester uses a valid/ready handshake. The block arbitrates between them, registers the operands and control code onto the ALU inputs, and waits an op-dependent number of cycles.
- It then captures the ALU result and Zero flag and returns them, tagged with the requester ID, on a response valid/ready channel.

Parameters:
- DATA_W, 32, operand/result width.
- CTRL_W, 4, ALU control code width.
- EXEC_CYCLES, 1, settle cycles before the result is sampled, for all ops except MUL; 0 is treated as 1.
- MUL_CYCLES, 3, settle cycles when the control code is 4'd9 (MUL); 0 is treated as 1.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Req0Valid  in  1  requester 0 has an op.
- Req0Ready  out  1  requester 0 op accepted this cycle.
- Req0Ctrl  in  CTRL_W  requester 0 ALU control code.
- Req0A  in  DATA_W  requester 0 operand A.
- Req0B  in  DATA_W  requester 0 operand B.
- Req1Valid, Req1Ready, Req1Ctrl, Req1A, Req1B  same directions, widths and meanings as requester 0.
- AluCtrl  out  CTRL_W  control code to the shared ALU (registered).
- AluA  out  DATA_W  operand A to the ALU (registered).
- AluB  out  DATA_W  operand B to the ALU (registered).
- AluResult  in  DATA_W  ALU result.
- AluZero  in  1  ALU Zero flag.
- RspValid  out  1  response available.
- RspReady  in  1  consumer takes the response.
- RspId  out  1  requester that owns the response.
- RspResult  out  DATA_W  captured result.
- RspZero  out  1  captured Zero flag.

Behaviour:
- Reset (async, Rst_n=0):
  - State=IDLE; RspValid=0, RspId=0, RspResult=0, RspZero=0.
  - AluCtrl=0, AluA=0, AluB=0; cycle counter=0; round-robin pointer=0 (requester 0 favoured).
  - Req0Ready/Req1Ready evaluate to 0.
- Reset mid-operation aborts the in-flight op: no response is produced and the request is lost.
- Handshake rules:
  - A transfer occurs on an edge where Valid&&Ready.
  - Requesters hold Valid and payload stable until the transfer.
  - ReqNReady is combinational: it is 1 only in IDLE, and only for the granted requester. At most one Ready is high per cycle.
- Grant rules:
  - Only one Valid high: that requester is granted.
  - Both Valid high: the requester selected by the pointer is granted.
- IDLE, on accept:
  - Latch Ctrl/A/B into AluCtrl/AluA/AluB and latch the tag.
  - Load counter = C-1, where C = MUL_CYCLES if Ctrl==4'd9, else EXEC_CYCLES.
  - Go to EXEC.
- EXEC:
  - Counter !=0: decrement.
  - Counter ==0: capture AluResult into RspResult and AluZero into RspZero; set RspId=tag and RspValid=1; go to RESP.
  - Latency: RspValid rises exactly C edges after the accepting edge.
- RESP:
  - Hold all Rsp outputs stable while RspValid=1 && RspReady=0.
  - On the edge with RspReady=1: RspValid=0, pointer = ~RspId (the other requester is favoured), go to IDLE.
  - RspReady already high when RspValid rises is legal; completion occurs on the next edge.
- Alu* outputs hold their last values outside EXEC; they change only on accept.
- No new accept in EXEC or RESP. Minimum per-op occupancy is C+2 cycles (accept, C settle edges, response, IDLE).
- Unknown control codes are passed through unchanged; the arbiter does not decode ops except for ==4'd9.
- Pointer updates only on response completion, not on accept.

Optional Feature:
- ARB_FIXED_PRIORITY_EN defined: requester 0 always wins when both are valid. The pointer register is removed and requester 1 can starve.
- Undefined (default): round-robin as specified above.

Test Plan:
- Single op, EXEC_CYCLES=1: Req0 ADD (Ctrl=2, A=5, B=7) accepted at edge N -> AluA=5/AluB=7 after N; RspValid=1, RspResult=12, RspZero=0, RspId=0 after edge N+1.
- MUL timing, MUL_CYCLES=3: Req1 Ctrl=9, A=6, B=7 -> RspValid rises exactly 3 edges after accept; RspResult=42, RspId=1.
- Contention: both Valid high continuously with SUB 3-3 -> grants alternate 0,1,0,1; each response RspResult=0, RspZero=1. Under ARB_FIXED_PRIORITY_EN, all grants go to 0.
- Backpressure: RspReady=0 for 5 cycles after RspValid -> Rsp outputs stable, Req0Ready/Req1Ready stay 0; RspReady=1 -> RspValid=0 next edge, IDLE accept possible the edge after.
- Reset mid-EXEC (MUL in flight, Rst_n pulsed low between edges) -> RspValid=0, Alu*=0 immediately; no response is ever produced for that op; a fresh request after reset completes normally.
